alu_multicycle: RTL and testbench

Parametrised execute-stage ALU with an iterative RV32M multiply/divide unit behind the same start/done handshake as the single-cycle ALU.
- Base integer and compare ops complete one edge after `start`.
- M-extension ops run a fixed-latency radix-2 sequencer.
- Sits in the execute stage, driven by the control unit's `ALU_control_t` decode plus an M-op select.

---
 rtl/alu_multicycle_if.sv | 73 +++++++
 rtl/alu_multicycle.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_multicycle_if.sv
// -----------------------------------------------------------------------------
// alu_multicycle_if
//
// Purpose:
//   Shared type package and request/response interface for the execute-stage
//   ALU. The package carries the base-op decode type produced by the control
//   unit. The interface bundles everything exchanged between the control unit
//   (master) and the ALU (slave). Clock and reset are not part of the bundle.
//
// Interface signals (master view):
//   start         out  request, taken by the ALU only while busy is low
//   control       out  base op (ALU_control_t), used when m_en is low
//   m_en          out  selects a multiply/divide op instead of control
//   m_op          out  RISC-V funct3 of the M op (MUL..REMU)
//   data1, data2  out  operands, captured on the accepting edge
//   result        in   registered result, held until the next completion
//   will_be_done  in   one-cycle completion pulse, coincident with result
//   busy          in   multiply/divide op in flight
//   illegal       in   registered with result; requested op not supported
// -----------------------------------------------------------------------------

package alu_multicycle_pkg;

    // Base op encoding from the control unit. Codes 14 and 15 are unused and
    // make the ALU return zero without flagging an illegal op.
    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_XOR  = 4'd2,
        ALU_ADD  = 4'd3,
        ALU_SUB  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_CE   = 4'd10,
        ALU_CNE  = 4'd11,
        ALU_CGE  = 4'd12,
        ALU_CGEU = 4'd13
    } ALU_control_t;

endpackage

interface alu_multicycle_if #(
    parameter int XLEN = 32
);
    import alu_multicycle_pkg::*;

    logic            start;
    ALU_control_t    control;
    logic            m_en;
    logic [2:0]      m_op;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic [XLEN-1:0] result;
    logic            will_be_done;
    logic            busy;
    logic            illegal;

    // Control unit side: issues requests, observes completion.
    modport master (
        output start, control, m_en, m_op, data1, data2,
        input  result, will_be_done, busy, illegal
    );

    // ALU side: accepts requests, produces completion.
    modport slave (
        input  start, control, m_en, m_op, data1, data2,
        output result, will_be_done, busy, illegal
    );

endinterface

// File: rtl/alu_multicycle.sv
// -----------------------------------------------------------------------------
// alu_multicycle
//
// Purpose:
//   Execute-stage ALU. Base integer and compare ops finish one edge after they
//   are accepted. RV32M multiply/divide ops run on an iterative radix-2
//   sequencer (shift-add multiply, restoring shift-subtract divide) with a
//   fixed latency of XLEN+1 edges, behind the same start/done handshake.
//
// Parameters:
//   XLEN   datapath width, power of two and at least 8
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   rst    synchronous active-high reset; aborts any op in flight
//   bus    alu_multicycle_if.slave request/response bundle
//
// Build option:
//   ALU_MULDIV_EN  when defined the multiply/divide sequencer is compiled in.
//                  When undefined no sequencer exists, busy is tied low and an
//                  M op completes in one edge with result 0 and illegal 1.
// -----------------------------------------------------------------------------

module alu_multicycle
    import alu_multicycle_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    alu_multicycle_if.slave    bus
);

    localparam int SH = $clog2(XLEN);

    logic [XLEN-1:0] result_q, result_d;
    logic            done_q, done_d;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] baseResult;
    logic [SH-1:0]   shiftAmount;

    assign shiftAmount = bus.data2[SH-1:0];

    // Single-cycle base op datapath. Compare ops return their outcome in bit 0
    // with the upper bits cleared; an unknown op code simply yields zero.
    always_comb begin
        baseResult = '0;
        case (bus.control)
            ALU_AND:  baseResult = bus.data1 & bus.data2;
            ALU_OR:   baseResult = bus.data1 | bus.data2;
            ALU_XOR:  baseResult = bus.data1 ^ bus.data2;
            ALU_ADD:  baseResult = bus.data1 + bus.data2;
            ALU_SUB:  baseResult = bus.data1 - bus.data2;
            ALU_SLL:  baseResult = bus.data1 << shiftAmount;
            ALU_SRL:  baseResult = bus.data1 >> shiftAmount;
            ALU_SRA:  baseResult = $signed(bus.data1) >>> shiftAmount;
            ALU_SLT:  baseResult = {{(XLEN-1){1'b0}}, $signed(bus.data1) < $signed(bus.data2)};
            ALU_SLTU: baseResult = {{(XLEN-1){1'b0}}, bus.data1 < bus.data2};
            ALU_CE:   baseResult = {{(XLEN-1){1'b0}}, bus.data1 == bus.data2};
            ALU_CNE:  baseResult = {{(XLEN-1){1'b0}}, bus.data1 != bus.data2};
            ALU_CGE:  baseResult = {{(XLEN-1){1'b0}}, $signed(bus.data1) >= $signed(bus.data2)};
            ALU_CGEU: baseResult = {{(XLEN-1){1'b0}}, bus.data1 >= bus.data2};
            default:  baseResult = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN

    localparam int W2 = 2 * XLEN;
    localparam logic [SH-1:0] LAST_STEP = SH'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic [XLEN-1:0] operand_q, operand_d;
    logic [SH-1:0]   stepCount_q, stepCount_d;
    logic [2:0]      op_q, op_d;
    logic            negResult_q, negResult_d;

    logic            signedA, signedB;
    logic            negA, negB;
    logic [XLEN-1:0] magA, magB;
    logic            divByZero;
    logic            negRequest;

    logic [XLEN:0]   mulSum;
    logic [W2-1:0]   mulNext;
    logic [XLEN:0]   shiftedRem;
    logic [XLEN:0]   trialRem;
    logic [W2-1:0]   divNext;
    logic [W2-1:0]   productSigned;
    logic [XLEN-1:0] quotient, remainder;
    logic [XLEN-1:0] fixResult;

    // Decide which operands of the requested M op are treated as signed.
    // MULHSU is the odd one out: data1 signed, data2 unsigned.
    always_comb begin
        signedA = 1'b0;
        signedB = 1'b0;
        case (bus.m_op)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                signedA = 1'b1;
                signedB = 1'b1;
            end
            3'd2: signedA = 1'b1;
            default: ;
        endcase
    end

    assign negA      = signedA & bus.data1[XLEN-1];
    assign negB      = signedB & bus.data2[XLEN-1];
    assign magA      = negA ? -bus.data1 : bus.data1;
    assign magB      = negB ? -bus.data2 : bus.data2;
    assign divByZero = (bus.data2 == '0);

    // Sign of the final result. Remainders follow the dividend. A quotient by
    // zero must stay all ones, so its sign correction is suppressed there;
    // the remainder by zero then naturally restores data1.
    always_comb begin
        negRequest = 1'b0;
        if (!bus.m_op[2]) begin
            negRequest = negA ^ negB;
        end else if (bus.m_op[1]) begin
            negRequest = negA;
        end else begin
            negRequest = (negA ^ negB) & ~divByZero;
        end
    end

    // One shift-add multiply step. The upper half accumulates the multiplicand
    // when the current multiplier bit (acc bit 0) is set, then the whole
    // product/multiplier pair shifts right with the carry moving in on top.
    assign mulSum  = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, operand_q} : '0);
    assign mulNext = {mulSum, acc_q[XLEN-1:1]};

    // One restoring divide step. The upper half is the partial remainder and
    // the lower half shifts the dividend out while quotient bits shift in.
    // A borrow out of the trial subtraction means the divisor did not fit.
    assign shiftedRem = {acc_q[W2-1:XLEN], acc_q[XLEN-1]};
    assign trialRem   = shiftedRem - {1'b0, operand_q};
    assign divNext    = trialRem[XLEN]
                      ? {shiftedRem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                      : {trialRem[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};

    // Final sign correction and half/quotient/remainder selection.
    assign productSigned = negResult_q ? -acc_q : acc_q;
    assign quotient      = negResult_q ? -acc_q[XLEN-1:0]  : acc_q[XLEN-1:0];
    assign remainder     = negResult_q ? -acc_q[W2-1:XLEN] : acc_q[W2-1:XLEN];

    always_comb begin
        fixResult = '0;
        case (op_q)
            3'd0:             fixResult = productSigned[XLEN-1:0];
            3'd1, 3'd2, 3'd3: fixResult = productSigned[W2-1:XLEN];
            3'd4, 3'd5:       fixResult = quotient;
            default:          fixResult = remainder;
        endcase
    end

    // Sequencer next state. In IDLE a base op completes immediately while an
    // M op loads its magnitudes; RUN iterates XLEN steps; FIX publishes the
    // corrected result. Requests arriving in RUN or FIX are simply dropped.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        operand_d   = operand_q;
        stepCount_d = stepCount_q;
        op_d        = op_q;
        negResult_d = negResult_q;
        result_d    = result_q;
        done_d      = 1'b0;
        illegal_d   = illegal_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.m_en) begin
                        acc_d       = {{XLEN{1'b0}}, bus.m_op[2] ? magA : magB};
                        operand_d   = bus.m_op[2] ? magB : magA;
                        stepCount_d = '0;
                        op_d        = bus.m_op;
                        negResult_d = negRequest;
                        state_d     = RUN;
                    end else begin
                        result_d  = baseResult;
                        done_d    = 1'b1;
                        illegal_d = 1'b0;
                    end
                end
            end
            RUN: begin
                acc_d       = op_q[2] ? divNext : mulNext;
                stepCount_d = stepCount_q + SH'(1);
                if (stepCount_q == LAST_STEP) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d  = fixResult;
                done_d    = 1'b1;
                illegal_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset; reset also drops any op in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            operand_q   <= '0;
            stepCount_q <= '0;
            op_q        <= '0;
            negResult_q <= 1'b0;
            result_q    <= '0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            operand_q   <= operand_d;
            stepCount_q <= stepCount_d;
            op_q        <= op_d;
            negResult_q <= negResult_d;
            result_q    <= result_d;
            done_q      <= done_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.busy = (state_q != IDLE);

`else

    logic unusedMop;

    // Without the sequencer the funct3 select has no consumer.
    assign unusedMop = ^bus.m_op;

    // Every request completes on the next edge; M ops are flagged illegal.
    always_comb begin
        result_d  = result_q;
        done_d    = 1'b0;
        illegal_d = illegal_q;
        if (bus.start) begin
            done_d = 1'b1;
            if (bus.m_en) begin
                result_d  = '0;
                illegal_d = 1'b1;
            end else begin
                result_d  = baseResult;
                illegal_d = 1'b0;
            end
        end
    end

    // Output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q  <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            result_q  <= result_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.busy = 1'b0;

`endif

    assign bus.result       = result_q;
    assign bus.will_be_done = done_q;
    assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// -----------------------------------------------------------------------------
// tb_alu_multicycle
//
// Purpose:
//   Directed self-checking bench for alu_multicycle at XLEN=32. Base ops,
//   handshake timing and reset are exercised in every build; the M-op tests
//   follow whichever ALU_MULDIV_EN build the design was compiled with.
// -----------------------------------------------------------------------------

module tb_alu_multicycle;
    import alu_multicycle_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    alu_multicycle_if #(.XLEN(XLEN)) bus ();

    alu_multicycle #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 ns clock period.
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, then all outputs must be at reset values.
    task automatic test_reset();
        bus.start   = 1'b0;
        bus.control = ALU_ADD;
        bus.m_en    = 1'b0;
        bus.m_op    = 3'd0;
        bus.data1   = '0;
        bus.data2   = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if (bus.result !== 32'h0) begin
            bad++; $display("[TB] FAIL reset_result: got %h want %h", bus.result, 32'h0);
        end
        total++;
        if (bus.will_be_done !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_done: got %b want 0", bus.will_be_done);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy);
        end
        total++;
        if (bus.illegal !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_illegal: got %b want 0", bus.illegal);
        end
    endtask

    // Directed base-op vectors; each completes one edge after start and the
    // done pulse must fall on the following edge.
    task automatic test_base_ops();
        ALU_control_t ctl [11];
        logic [31:0]  a   [11];
        logic [31:0]  b   [11];
        logic [31:0]  exp [11];
        ctl = '{ALU_ADD, ALU_SRA, ALU_control_t'(4'hF), ALU_SLT, ALU_SLTU, ALU_XOR,
                ALU_SLL, ALU_SUB, ALU_CGE, ALU_CGEU, ALU_CE};
        a   = '{32'hFFFFFFFF, 32'h80000000, 32'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0,
                32'd1, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5};
        b   = '{32'd1, 32'd4, 32'd34, 32'd1, 32'd1, 32'h0FF00FF0,
                32'h25, 32'd7, 32'd1, 32'd1, 32'd5};
        exp = '{32'h00000000, 32'hF8000000, 32'h00000000, 32'h00000001, 32'h00000000, 32'hFF00FF00,
                32'h00000020, 32'hFFFFFFFE, 32'h00000000, 32'h00000001, 32'h00000001};
        for (int i = 0; i < 11; i++) begin
            bus.start   = 1'b1;
            bus.m_en    = 1'b0;
            bus.control = ctl[i];
            bus.data1   = a[i];
            bus.data2   = b[i];
            tick();
            bus.start = 1'b0;
            bus.data1 = 32'hDEADBEEF;
            bus.data2 = 32'h12345678;
            total++;
            if (bus.result !== exp[i]) begin
                bad++; $display("[TB] FAIL base_result[%0d]: got %h want %h", i, bus.result, exp[i]);
            end
            total++;
            if (bus.will_be_done !== 1'b1) begin
                bad++; $display("[TB] FAIL base_done[%0d]: got %b want 1", i, bus.will_be_done);
            end
            total++;
            if (bus.illegal !== 1'b0) begin
                bad++; $display("[TB] FAIL base_illegal[%0d]: got %b want 0", i, bus.illegal);
            end
            tick();
            total++;
            if (bus.will_be_done !== 1'b0) begin
                bad++; $display("[TB] FAIL base_done_drop[%0d]: got %b want 0", i, bus.will_be_done);
            end
            total++;
            if (bus.result !== exp[i]) begin
                bad++; $display("[TB] FAIL base_hold[%0d]: got %h want %h", i, bus.result, exp[i]);
            end
        end
    endtask

    // Reset asserted together with start: the request must be discarded.
    task automatic test_rst_wins();
        bus.start   = 1'b1;
        bus.m_en    = 1'b0;
        bus.control = ALU_ADD;
        bus.data1   = 32'd1;
        bus.data2   = 32'd1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.start = 1'b0;
        total++;
        if (bus.result !== 32'h0) begin
            bad++; $display("[TB] FAIL rst_wins_result: got %h want %h", bus.result, 32'h0);
        end
        total++;
        if (bus.will_be_done !== 1'b0) begin
            bad++; $display("[TB] FAIL rst_wins_done: got %b want 0", bus.will_be_done);
        end
    endtask

    // Two base ops on consecutive edges: done stays high, result updates.
    task automatic test_back_to_back();
        bus.start   = 1'b1;
        bus.m_en    = 1'b0;
        bus.control = ALU_ADD;
        bus.data1   = 32'd2;
        bus.data2   = 32'd3;
        tick();
        total++;
        if (bus.result !== 32'd5 || bus.will_be_done !== 1'b1) begin
            bad++; $display("[TB] FAIL b2b_first: got %h/%b want %h/1", bus.result, bus.will_be_done, 32'd5);
        end
        bus.control = ALU_SUB;
        bus.data1   = 32'd10;
        bus.data2   = 32'd4;
        tick();
        bus.start = 1'b0;
        total++;
        if (bus.result !== 32'd6 || bus.will_be_done !== 1'b1) begin
            bad++; $display("[TB] FAIL b2b_second: got %h/%b want %h/1", bus.result, bus.will_be_done, 32'd6);
        end
        tick();
        total++;
        if (bus.will_be_done !== 1'b0 || bus.result !== 32'd6) begin
            bad++; $display("[TB] FAIL b2b_idle: got %h/%b want %h/0", bus.result, bus.will_be_done, 32'd6);
        end
    endtask

`ifdef ALU_MULDIV_EN

    // Issue one M op, scramble the operands after the accepting edge, and
    // report the result, the edge count to done and whether busy behaved.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output int edges, output logic busyOk);
        bus.start = 1'b1;
        bus.m_en  = 1'b1;
        bus.m_op  = op;
        bus.data1 = a;
        bus.data2 = b;
        tick();
        bus.start = 1'b0;
        bus.data1 = $urandom;
        bus.data2 = $urandom;
        edges  = 0;
        busyOk = 1'b1;
        while (bus.will_be_done !== 1'b1 && edges < 40) begin
            if (bus.busy !== 1'b1) busyOk = 1'b0;
            tick();
            edges++;
        end
        if (bus.busy !== 1'b0) busyOk = 1'b0;
        res = bus.result;
    endtask

    // The four multiply flavours on all-ones operands.
    task automatic test_mul();
        logic [31:0] res;
        int          edges;
        logic        busyOk;
        logic [31:0] exp [4];
        exp = '{32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'(i), 32'hFFFFFFFF, 32'hFFFFFFFF, res, edges, busyOk);
            total++;
            if (res !== exp[i]) begin
                bad++; $display("[TB] FAIL mul_result[%0d]: got %h want %h", i, res, exp[i]);
            end
            total++;
            if (edges !== 33) begin
                bad++; $display("[TB] FAIL mul_latency[%0d]: got %0d want 33", i, edges);
            end
            total++;
            if (busyOk !== 1'b1) begin
                bad++; $display("[TB] FAIL mul_busy[%0d]: got %b want 1", i, busyOk);
            end
            total++;
            if (bus.illegal !== 1'b0) begin
                bad++; $display("[TB] FAIL mul_illegal[%0d]: got %b want 0", i, bus.illegal);
            end
        end
    endtask

    // Signed/unsigned division corner cases.
    task automatic test_div();
        logic [31:0] res;
        int          edges;
        logic        busyOk;
        logic [2:0]  op  [8];
        logic [31:0] a   [8];
        logic [31:0] b   [8];
        logic [31:0] exp [8];
        op  = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
        a   = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7, 32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9};
        b   = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
        exp = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF9};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(op[i], a[i], b[i], res, edges, busyOk);
            total++;
            if (res !== exp[i]) begin
                bad++; $display("[TB] FAIL div_result[%0d]: got %h want %h", i, res, exp[i]);
            end
            total++;
            if (edges !== 33 || busyOk !== 1'b1) begin
                bad++; $display("[TB] FAIL div_timing[%0d]: got %0d/%b want 33/1", i, edges, busyOk);
            end
        end
    endtask

    // start held high through a DIV with junk operands: only the original
    // request completes, and a new op issued in the done cycle is taken.
    task automatic test_busy_ignore();
        int edges;
        bus.start = 1'b1;
        bus.m_en  = 1'b1;
        bus.m_op  = 3'd4;
        bus.data1 = 32'd100;
        bus.data2 = 32'd7;
        tick();
        edges = 0;
        while (bus.will_be_done !== 1'b1 && edges < 40) begin
            bus.m_op  = 3'($urandom_range(0, 7));
            bus.data1 = $urandom;
            bus.data2 = $urandom;
            tick();
            edges++;
        end
        total++;
        if (edges !== 33 || bus.result !== 32'd14) begin
            bad++; $display("[TB] FAIL ignore_first: got %0d/%h want 33/%h", edges, bus.result, 32'd14);
        end
        bus.m_op  = 3'd5;
        bus.data1 = 32'd50;
        bus.data2 = 32'd5;
        tick();
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.will_be_done !== 1'b0) begin
            bad++; $display("[TB] FAIL ignore_accept: got busy=%b done=%b want 1/0", bus.busy, bus.will_be_done);
        end
        edges = 0;
        while (bus.will_be_done !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        total++;
        if (edges !== 33 || bus.result !== 32'd10) begin
            bad++; $display("[TB] FAIL ignore_second: got %0d/%h want 33/%h", edges, bus.result, 32'd10);
        end
    endtask

    // Reset during RUN step 10 aborts the multiply without a done pulse.
    task automatic test_reset_mid();
        int dones;
        bus.start = 1'b1;
        bus.m_en  = 1'b1;
        bus.m_op  = 3'd0;
        bus.data1 = 32'd3;
        bus.data2 = 32'd5;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (bus.result !== 32'h0 || bus.will_be_done !== 1'b0 || bus.busy !== 1'b0 || bus.illegal !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_mid_outputs: got %h/%b/%b/%b want 0/0/0/0",
                            bus.result, bus.will_be_done, bus.busy, bus.illegal);
        end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.will_be_done === 1'b1) dones++;
            tick();
        end
        total++;
        if (dones !== 0) begin
            bad++; $display("[TB] FAIL reset_mid_done: got %0d pulses want 0", dones);
        end
    endtask

`else

    // Without the sequencer an M op finishes in one edge as illegal.
    task automatic test_no_muldiv();
        logic sawBusy;
        bus.start = 1'b1;
        bus.m_en  = 1'b1;
        bus.m_op  = 3'd0;
        bus.data1 = 32'd3;
        bus.data2 = 32'd5;
        sawBusy = bus.busy;
        tick();
        bus.start = 1'b0;
        if (bus.busy !== 1'b0) sawBusy = 1'b1;
        total++;
        if (bus.will_be_done !== 1'b1) begin
            bad++; $display("[TB] FAIL nomd_done: got %b want 1", bus.will_be_done);
        end
        total++;
        if (bus.result !== 32'h0) begin
            bad++; $display("[TB] FAIL nomd_result: got %h want %h", bus.result, 32'h0);
        end
        total++;
        if (bus.illegal !== 1'b1) begin
            bad++; $display("[TB] FAIL nomd_illegal: got %b want 1", bus.illegal);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.busy !== 1'b0) sawBusy = 1'b1;
        end
        total++;
        if (sawBusy !== 1'b0) begin
            bad++; $display("[TB] FAIL nomd_busy: got %b want 0", sawBusy);
        end
        bus.start   = 1'b1;
        bus.m_en    = 1'b0;
        bus.control = ALU_ADD;
        bus.data1   = 32'd1;
        bus.data2   = 32'd2;
        tick();
        bus.start = 1'b0;
        total++;
        if (bus.result !== 32'd3 || bus.illegal !== 1'b0) begin
            bad++; $display("[TB] FAIL nomd_base_after: got %h/%b want %h/0", bus.result, bus.illegal, 32'd3);
        end
    endtask

`endif

    // Hard stop in case the bench itself wedges.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence.
    initial begin
        test_reset();
        test_base_ops();
        test_rst_wins();
        test_back_to_back();
`ifdef ALU_MULDIV_EN
        test_mul();
        test_div();
        test_busy_ignore();
        test_reset_mid();
`else
        test_no_muldiv();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
